noc_merge_arbiter: RTL and testbench
====================================

Name: noc_merge_arbiter

Overview:
- Clocked 2:1 weighted round-robin arbiter for the fat-tree NoC.
- Merges two single-flit packet streams into one shared outgoing link, e.g. the child-to-parent uplink of a routing node fed by both children.
- Registered output stage: one flit per cycle, 1-cycle latency.
- Destination field (bits DST_HI:DST_LO) is carried through untouched.

Parameters:
- WIDTH, 32, flit width in bits.
- WEIGHT0, 1, consecutive grants to input 0 under contention before priority passes; legal 1..15.
- WEIGHT1, 1, same for input 1; legal 1..15.
- DST_HI, 26, MSB of destination address field; used only by the optional feature.
- DST_LO, 24, LSB of destination address field.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in0_valid  in  1  input 0 has a flit.
- in0_data  in  WIDTH  input 0 flit.
- in0_ready  out  1  input 0 flit accepted this cycle.
- in1_valid  in  1  input 1 has a flit.
- in1_data  in  WIDTH  input 1 flit.
- in1_ready  out  1  input 1 flit accepted this cycle.
- out_valid  out  1  output register holds a flit.
- out_data  out  WIDTH  output flit.
- out_src  out  1  which input supplied out_data.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Transfer occurs on a port when valid and ready are both high at a clock edge. in_valid must be held, with data stable, until accepted. out_valid, once high, is held until accepted.
- State:
  - ptr: preferred input, 1 bit.
  - cnt: grants given to ptr in the current turn, 4 bits.
  - out register: out_valid, out_data, out_src.
- Reset values (asynchronous on rst_n low):
  - out_valid=0, out_data=0, out_src=0.
  - ptr=0, cnt=0.
  - in0_ready=0, in1_ready=0 while rst_n is low.
  - Any flit held in the output register is dropped.
- slot_free = !out_valid || out_ready.
- Grant is combinational from registered state and current valids:
  - in0_ready = slot_free && in0_valid && (ptr==0 || !in1_valid).
  - in1_ready = slot_free && in1_valid && (ptr==1 || !in0_valid).
  - At most one ready is high per cycle.
  - ready never depends on out_valid of the same cycle's new load.
- On a grant to input g:
  - out_data<=in_g_data, out_src<=g, out_valid<=1.
  - If g==ptr:
    - When cnt+1 == WEIGHT[ptr]: ptr<=~ptr, cnt<=0.
    - Otherwise: cnt<=cnt+1.
  - If g!=ptr (preferred input idle): ptr and cnt unchanged.
- No grant and out_ready high: out_valid<=0.
- Throughput: back-to-back flits every cycle while out_ready=1. A flit appears on out_* one cycle after its acceptance.
- Backpressure: out_valid=1 and out_ready=0 gives both in_ready=0. No state change.
- Simultaneous accept-and-load in the same cycle is legal; the register is overwritten with the new flit.
- Fairness: under continuous contention the grant pattern is WEIGHT0 flits from input 0, then WEIGHT1 from input 1, repeating. No starvation.
- An illegal WEIGHT (0 or >15) is a compile-time error.

Optional Feature:
- Macro: NOC_MERGE_ARBITER_STATS_EN.
- When defined, adds these ports:
  - stat_grant0  out  16  grants to input 0.
  - stat_grant1  out  16  grants to input 1.
  - stat_stall  out  16  cycles with out_valid && !out_ready.
  - stat_last_dst  out  DST_HI-DST_LO+1  destination field of the last accepted flit.
- Counters are saturating and reset to 0 by rst_n. Saturation holds at 16'hFFFF, with no wrap.
- When undefined: none of these ports or registers exist, and behaviour is otherwise identical.

Decomposition:
- Shared package noc_pkg holds:
  - flit width constant (32);
  - DST_HI/DST_LO constants (26/24);
  - addr_t typedef (3-bit);
  - flit_t typedef.
- One natural sub-module: noc_wrr_pick, the combinational pick plus ptr/cnt update. It is reused by wider merges later.
- The output register stays in the top module.

Test Plan:
- Reset: hold rst_n=0 with in0_valid=1 → out_valid=0, in0_ready=0. Release → first flit (e.g. 32'h0500_0001) appears with out_valid=1, out_src=0 one cycle after acceptance.
- Contention, WEIGHT0=2, WEIGHT1=1, both inputs always valid, out_ready=1 → out_src sequence 0,0,1,0,0,1 over 6 cycles, one flit per cycle.
- Single requester: in1 only, 4 flits → 4 consecutive grants to in1 with ptr unchanged at 0. A following contention cycle grants in0 first.
- Backpressure: out_ready=0 for 3 cycles with both valid → out_data stable, both ready=0. Release → resumes with no flit lost or duplicated.
- Reset mid-operation: assert rst_n low asynchronously between edges while out_valid=1 → out_valid drops immediately, ptr=0, cnt=0. The held flit is not delivered.
- With NOC_MERGE_ARBITER_STATS_EN: 10 grants to in0 and 7 to in1, plus 3 stall cycles → stat_grant0=10, stat_grant1=7, stat_stall=3. stat_last_dst equals bits 26:24 of the final accepted flit (e.g. 3'b101).

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, destination field position and small
// helpers used by the merge arbiter and its weighted round-robin picker.
package noc_pkg;

  localparam int FLIT_W = 32;
  localparam int DST_HI = 26;
  localparam int DST_LO = 24;

  typedef logic [DST_HI-DST_LO:0] addr_t;
  typedef logic [FLIT_W-1:0]      flit_t;

  // Turn length for the preferred input, narrowed to the 4-bit grant counter.
  function automatic logic [3:0] wrr_weight(input logic sel, input int w0, input int w1);
    wrr_weight = sel ? 4'(w1) : 4'(w0);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/noc_wrr_pick.sv
// Combinational 2-way weighted round-robin pick with next ptr/cnt.
// The preferred input keeps priority for WEIGHTn grants; an idle preferred input lets the other through.
module noc_wrr_pick #(
  parameter int WEIGHT0 = 1,
  parameter int WEIGHT1 = 1
) (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       slot_free_i,
  input  logic       ptr_i,
  input  logic [3:0] cnt_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  output logic       ptr_o,
  output logic [3:0] cnt_o
);
  import noc_pkg::*;

  if (WEIGHT0 < 1 || WEIGHT0 > 15) begin : g_bad_weight0
    $error("noc_wrr_pick: WEIGHT0 must be in 1..15");
  end
  if (WEIGHT1 < 1 || WEIGHT1 > 15) begin : g_bad_weight1
    $error("noc_wrr_pick: WEIGHT1 must be in 1..15");
  end

  logic [3:0] weight_s;
  logic       hit_ptr_s;

  always_comb begin
    gnt0_o    = slot_free_i && req0_i && (!ptr_i || !req1_i);
    gnt1_o    = slot_free_i && req1_i && (ptr_i || !req0_i);
    weight_s  = wrr_weight(ptr_i, WEIGHT0, WEIGHT1);
    hit_ptr_s = ptr_i ? gnt1_o : gnt0_o;
    ptr_o     = ptr_i;
    cnt_o     = cnt_i;
    if (hit_ptr_s) begin
      if (cnt_i + 4'd1 == weight_s) begin
        ptr_o = ~ptr_i;
        cnt_o = 4'd0;
      end else begin
        cnt_o = cnt_i + 4'd1;
      end
    end else begin
      ptr_o = ptr_i;
      cnt_o = cnt_i;
    end
  end

endmodule

// File: rtl/noc_merge_arbiter.sv
// 2:1 weighted round-robin merge onto one registered NoC link (1-cycle latency).
// Define NOC_MERGE_ARBITER_STATS_EN to add saturating grant/stall counters and last destination.
module noc_merge_arbiter #(
  parameter int WIDTH   = noc_pkg::FLIT_W,
  parameter int WEIGHT0 = 1,
  parameter int WEIGHT1 = 1,
  parameter int DST_HI  = noc_pkg::DST_HI,
  parameter int DST_LO  = noc_pkg::DST_LO
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in0_valid,
  input  logic [WIDTH-1:0]       in0_data,
  output logic                   in0_ready,
  input  logic                   in1_valid,
  input  logic [WIDTH-1:0]       in1_data,
  output logic                   in1_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_src,
`ifdef NOC_MERGE_ARBITER_STATS_EN
  output logic [15:0]            stat_grant0,
  output logic [15:0]            stat_grant1,
  output logic [15:0]            stat_stall,
  output logic [DST_HI-DST_LO:0] stat_last_dst,
`endif
  input  logic                   out_ready
);
  import noc_pkg::*;

  if (DST_LO < 0 || DST_LO > DST_HI || DST_HI >= WIDTH) begin : g_bad_dst
    $error("noc_merge_arbiter: destination field must lie inside the flit");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             slot_free_s, gnt0_s, gnt1_s;

  // Gating with rst_n keeps both readies low for the whole reset window.
  assign slot_free_s = rst_n && (!out_valid_q || out_ready);

  noc_wrr_pick #(
    .WEIGHT0(WEIGHT0),
    .WEIGHT1(WEIGHT1)
  ) u_pick (
    .req0_i      (in0_valid),
    .req1_i      (in1_valid),
    .slot_free_i (slot_free_s),
    .ptr_i       (ptr_q),
    .cnt_i       (cnt_q),
    .gnt0_o      (gnt0_s),
    .gnt1_o      (gnt1_s),
    .ptr_o       (ptr_d),
    .cnt_o       (cnt_d)
  );

  assign in0_ready = gnt0_s;
  assign in1_ready = gnt1_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (gnt0_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in0_data;
      out_src_d   = 1'b0;
    end else if (gnt1_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in1_data;
      out_src_d   = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      ptr_q       <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef NOC_MERGE_ARBITER_STATS_EN
  logic [15:0]            grant0_q, grant1_q, stall_q;
  logic [DST_HI-DST_LO:0] last_dst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_q   <= 16'd0;
      grant1_q   <= 16'd0;
      stall_q    <= 16'd0;
      last_dst_q <= '0;
    end else begin
      if (gnt0_s) begin
        grant0_q   <= sat_inc16(grant0_q);
        last_dst_q <= in0_data[DST_HI:DST_LO];
      end else if (gnt1_s) begin
        grant1_q   <= sat_inc16(grant1_q);
        last_dst_q <= in1_data[DST_HI:DST_LO];
      end
      if (out_valid_q && !out_ready) begin
        stall_q <= sat_inc16(stall_q);
      end
    end
  end

  assign stat_grant0   = grant0_q;
  assign stat_grant1   = grant1_q;
  assign stat_stall    = stall_q;
  assign stat_last_dst = last_dst_q;
`endif

endmodule

// File: tb/tb_noc_merge_arbiter.sv
// Randomized self-checking bench for noc_merge_arbiter (WEIGHT0=2, WEIGHT1=1) against
// a turn-quota reference model, plus directed reset/contention/backpressure scenarios.
module tb_noc_merge_arbiter;

  localparam int W0 = 2;
  localparam int W1 = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in0_valid, in1_valid, out_ready;
  logic [31:0] in0_data, in1_data;
  logic        in0_ready, in1_ready, out_valid, out_src;
  logic [31:0] out_data;
`ifdef NOC_MERGE_ARBITER_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_stall;
  logic [2:0]  stat_last_dst;
`endif

  always #5 clk = ~clk;

  noc_merge_arbiter #(
    .WIDTH(32), .WEIGHT0(W0), .WEIGHT1(W1), .DST_HI(26), .DST_LO(24)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
`ifdef NOC_MERGE_ARBITER_STATS_EN
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
    .stat_stall(stat_stall), .stat_last_dst(stat_last_dst),
`endif
    .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: the preferred input owns a quota of grants per turn.
  logic        m_valid, m_src;
  logic [31:0] m_data;
  int          pref, remaining;
  bit          acc0, acc1;
  int          m_g0, m_g1, m_stall;
  logic [2:0]  m_dst;
  logic [31:0] seq0, seq1;

  function automatic int quota(input int p);
    return (p == 0) ? W0 : W1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_src = 1'b0; m_data = 32'd0;
    pref = 0; remaining = quota(0);
    acc0 = 1'b0; acc1 = 1'b0;
    m_g0 = 0; m_g1 = 0; m_stall = 0; m_dst = 3'd0;
  endtask

  task automatic take(input int g);
    if (g == pref) begin
      remaining--;
      if (remaining == 0) begin
        pref = 1 - pref;
        remaining = quota(pref);
      end
    end
  endtask

  // mode: 0 random, 1 both contend, 2 in1 only, 3 both contend with out_ready=0, 4 inputs untouched.
  task automatic step(input int mode);
    bit slot, e0, e1;
    if (mode != 4) begin
      if (mode == 2) begin
        in0_valid = 1'b0;
      end else if (!in0_valid || acc0) begin
        if (mode == 0) begin
          in0_valid = ($urandom % 3) != 0; in0_data = $urandom;
        end else begin
          seq0++; in0_valid = 1'b1; in0_data = seq0;
        end
      end
      if (!in1_valid || acc1) begin
        if (mode == 0) begin
          in1_valid = ($urandom % 3) != 0; in1_data = $urandom;
        end else begin
          seq1++; in1_valid = 1'b1; in1_data = seq1;
        end
      end
      out_ready = (mode == 3) ? 1'b0 : (mode == 0) ? (($urandom % 4) != 0) : 1'b1;
    end
    #1;
    slot = !m_valid || out_ready;
    e0 = slot && in0_valid && (pref == 0 || !in1_valid);
    e1 = slot && in1_valid && (pref == 1 || !in0_valid);
    check_eq("in0_ready", {31'd0, in0_ready}, {31'd0, e0});
    check_eq("in1_ready", {31'd0, in1_ready}, {31'd0, e1});
    if (m_valid && !out_ready && m_stall < 65535) m_stall++;
    if (e0) begin
      m_valid = 1'b1; m_data = in0_data; m_src = 1'b0; m_dst = in0_data[26:24];
      if (m_g0 < 65535) m_g0++;
      take(0);
    end else if (e1) begin
      m_valid = 1'b1; m_data = in1_data; m_src = 1'b1; m_dst = in1_data[26:24];
      if (m_g1 < 65535) m_g1++;
      take(1);
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    acc0 = e0; acc1 = e1;
    @(negedge clk);
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_eq("out_src", {31'd0, out_src}, {31'd0, m_src});
    if (m_valid) check_eq("out_data", out_data, m_data);
  endtask

  // Asynchronous reset asserted between clock edges, released on a later falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
    check_eq("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit          exp_seq [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] held;

  initial begin
    rst_n = 1'b0;
    in0_valid = 1'b1; in0_data = 32'h0500_0001;
    in1_valid = 1'b0; in1_data = 32'd0;
    out_ready = 1'b1;
    seq0 = 32'h0100_0000; seq1 = 32'h0600_0000;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset_in0_ready", {31'd0, in0_ready}, 32'd0);
    check_eq("reset_out_src", {31'd0, out_src}, 32'd0);
    rst_n = 1'b1;
    step(4);
    check_eq("first_valid", {31'd0, out_valid}, 32'd1);
    check_eq("first_data", out_data, 32'h0500_0001);
    check_eq("first_src", {31'd0, out_src}, 32'd0);

    // out_valid is high here; the held flit must vanish.
    in0_valid = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1);
      check_eq("wrr_seq", {31'd0, out_src}, {31'd0, exp_seq[i]});
      check_eq("wrr_valid", {31'd0, out_valid}, 32'd1);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(2);
      check_eq("solo_src", {31'd0, out_src}, 32'd1);
    end
    step(1);
    check_eq("after_solo_src", {31'd0, out_src}, 32'd0);

    do_reset();
    step(1);
    step(1);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      step(3);
      check_eq("bp_data_stable", out_data, held);
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    for (int i = 0; i < 4; i++) step(1);

    do_reset();
    for (int i = 0; i < 400; i++) step(0);

`ifdef NOC_MERGE_ARBITER_STATS_EN
    check_eq("stat_grant0", {16'd0, stat_grant0}, m_g0);
    check_eq("stat_grant1", {16'd0, stat_grant1}, m_g1);
    check_eq("stat_stall", {16'd0, stat_stall}, m_stall);
    check_eq("stat_last_dst", {29'd0, stat_last_dst}, {29'd0, m_dst});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
